// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch sequencer for the RV32IM core.
// It owns the fetch PC and drives the byte address of a combinational instruction memory.
// Fetched words are buffered in a small prefetch FIFO and handed to decode over a valid/ready handshake.
// A redirect from execute flushes the FIFO and restarts fetch at the (word-aligned) target.
// Ports:
//   clk, rst_n         core clock; asynchronous active-low reset
//   fetch_en           enables fetching; low holds the PC and stops pushes
//   imem_addr/data     instruction memory byte address out, word in (combinational)
//   redirect_valid/pc  one-cycle redirect request and target byte address
//   ins_valid/ready    decode handshake for the FIFO head
//   ins_data/pc        head instruction word and its byte address (NOP/0 when empty)
// Optional build macro IFU_PERF_CNT_EN adds perf_fetched (pops) and perf_bubbles
// (cycles with fetch_en high and no valid instruction) 32-bit counters.
module instr_fetch_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  ins_valid,
  input  logic                  ins_ready,
  output logic [31:0]           ins_data,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_bubbles,
`endif
  output logic [ADDR_WIDTH-1:0] ins_pc
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state, state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] pc_q [FIFO_DEPTH];
  logic [31:0] data_q [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0] count;
  logic fetching, push, pop;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = fetch_en ? FETCH : IDLE;
      FETCH:   state_next = fetch_en ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
    fetching = (state_next == FETCH);
    pop = ins_valid && ins_ready;
    // a full FIFO can still accept a word when the head leaves this cycle
    push = fetching && !redirect_valid && ((count < DEPTH) || pop);
  end
  assign imem_addr = fetch_pc;
  assign ins_valid = (count != '0);
  assign ins_data = ins_valid ? data_q[rptr] : NOP;
  assign ins_pc = ins_valid ? pc_q[rptr] : '0;
  // redirect wins over push and pop; a same-cycle pop is discarded with the flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~ADDR_WIDTH'(3);
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wptr] <= fetch_pc;
      data_q[wptr] <= imem_data;
    end
  end
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (fetch_en && !ins_valid) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed self-checking bench for instr_fetch_ctrl.
module tb_instr_fetch_ctrl;
  logic clk = 0;
  logic rst_n, fetch_en, redirect_valid, ins_ready, ins_valid;
  logic [7:0] imem_addr, redirect_pc, ins_pc;
  logic [31:0] imem_data, ins_data;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [7:0] a);
    return (a == 8'h00) ? 32'h0050_0093 : (a == 8'h04) ? 32'h00A0_0113 : (32'hA000_0000 | 32'(a));
  endfunction
  assign imem_data = word(imem_addr);
  instr_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .ins_data(ins_data),
`ifdef IFU_PERF_CNT_EN
    .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles),
`endif
    .ins_pc(ins_pc)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic head(input string tag, input logic [7:0] pc);
    chk({tag, "_valid"}, 32'(ins_valid), 32'd1);
    chk({tag, "_pc"}, 32'(ins_pc), 32'(pc));
    chk({tag, "_data"}, ins_data, word(pc));
  endtask
  task automatic empty(input string tag);
    chk({tag, "_valid"}, 32'(ins_valid), 32'd0);
    chk({tag, "_data"}, ins_data, 32'h0000_0013);
    chk({tag, "_pc"}, 32'(ins_pc), 32'd0);
  endtask
  initial begin
    rst_n = 0; fetch_en = 0; ins_ready = 0; redirect_valid = 0; redirect_pc = 0;
    repeat (2) @(negedge clk);
    empty("rst");
    chk("rst_addr", 32'(imem_addr), 32'h00);
    rst_n = 1; fetch_en = 1; ins_ready = 1;
    empty("lat0");
    @(negedge clk); head("c1", 8'h00);
    @(negedge clk); head("c2", 8'h04);
    @(negedge clk); head("c3", 8'h08);
    rst_n = 0; #1;
    empty("midrst");
    chk("midrst_addr", 32'(imem_addr), 32'h00);
    @(negedge clk); rst_n = 1; ins_ready = 0;
    repeat (5) @(negedge clk);
    head("full", 8'h00);
    chk("full_addr", 32'(imem_addr), 32'h08);
    ins_ready = 1;
    @(negedge clk); head("drain1", 8'h04);
    @(negedge clk); head("drain2", 8'h08);
    ins_ready = 0; redirect_valid = 1; redirect_pc = 8'h2B;
    @(negedge clk);
    redirect_valid = 0; ins_ready = 1;
    chk("redir_valid", 32'(ins_valid), 32'd0);
    chk("redir_addr", 32'(imem_addr), 32'h28);
    @(negedge clk); head("redir_t", 8'h28);
    @(negedge clk); head("redir_t4", 8'h2C);
    ins_ready = 0;
    @(negedge clk); head("fill", 8'h2C);
    ins_ready = 1; redirect_valid = 1; redirect_pc = 8'hF8;
    @(negedge clk);
    redirect_valid = 0;
    chk("rpop_valid", 32'(ins_valid), 32'd0);
    chk("rpop_addr", 32'(imem_addr), 32'hF8);
    @(negedge clk); head("rpop_t", 8'hF8);
    @(negedge clk); head("wrap_fc", 8'hFC);
    chk("wrap_addr", 32'(imem_addr), 32'h00);
    @(negedge clk); head("wrap_00", 8'h00);
    ins_ready = 0;
    @(negedge clk);
    fetch_en = 0; ins_ready = 1;
    chk("stop_addr", 32'(imem_addr), 32'h08);
    @(negedge clk); head("stop_d", 8'h04);
    chk("stop_addr2", 32'(imem_addr), 32'h08);
    @(negedge clk); chk("stop_empty", 32'(ins_valid), 32'd0);
    @(negedge clk); chk("stop_addr3", 32'(imem_addr), 32'h08);
    redirect_valid = 1; redirect_pc = 8'h41;
    @(negedge clk);
    redirect_valid = 0;
    chk("idle_redir_addr", 32'(imem_addr), 32'h40);
    chk("idle_redir_valid", 32'(ins_valid), 32'd0);
    fetch_en = 1;
    @(negedge clk); head("resume", 8'h40);
`ifdef IFU_PERF_CNT_EN
    rst_n = 0; fetch_en = 0;
    @(negedge clk);
    rst_n = 1; fetch_en = 1; ins_ready = 1;
    repeat (10) @(negedge clk);
    chk("perf_fetched", perf_fetched, 32'd9);
    chk("perf_bubbles", perf_bubbles, 32'd1);
    rst_n = 0; #1;
    chk("perf_fetched_rst", perf_fetched, 32'd0);
    chk("perf_bubbles_rst", perf_bubbles, 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
